// File: rtl/mandelbrot_depth_unit.sv
// Iterative Mandelbrot escape-time core: one z = z^2 + c step per cycle from z = 0,
// returning the escape depth together with the pixel tags of the point.
module mandelbrot_depth_unit #(
  parameter int unsigned WORD_LENGTH = 32,
  parameter int unsigned FRAC        = 28,
  parameter int unsigned DEPTH_WIDTH = 10,
  parameter int unsigned COORD_WIDTH = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WORD_LENGTH-1:0] c_re,
  input  logic [WORD_LENGTH-1:0] c_im,
  input  logic [COORD_WIDTH-1:0] in_x,
  input  logic [COORD_WIDTH-1:0] in_y,
  input  logic [31:0]            max_iter,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DEPTH_WIDTH-1:0] depth,
  output logic [COORD_WIDTH-1:0] out_x,
  output logic [COORD_WIDTH-1:0] out_y,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int unsigned PW = 2 * WORD_LENGTH;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StIter = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [DEPTH_WIDTH-1:0] IterCap = '1;
  // 4.0 expressed in the scale of a full-width product (2*FRAC fractional bits).
  localparam logic [PW-1:0] EscThresh = {{(PW - 3){1'b0}}, 3'b100} << (2 * FRAC);

  logic [1:0]                    state_q, state_d;
  logic                          init_q;
  logic signed [WORD_LENGTH-1:0] cre_q, cre_d;
  logic signed [WORD_LENGTH-1:0] cim_q, cim_d;
  logic signed [WORD_LENGTH-1:0] zr_q, zr_d;
  logic signed [WORD_LENGTH-1:0] zi_q, zi_d;
  logic [COORD_WIDTH-1:0]        tag_x_q, tag_x_d;
  logic [COORD_WIDTH-1:0]        tag_y_q, tag_y_d;
  logic [DEPTH_WIDTH-1:0]        lim_q, lim_d;
  logic [DEPTH_WIDTH-1:0]        iter_q, iter_d;
  logic [DEPTH_WIDTH-1:0]        depth_q, depth_d;
  logic [COORD_WIDTH-1:0]        out_x_q, out_x_d;
  logic [COORD_WIDTH-1:0]        out_y_q, out_y_d;

  logic signed [PW-1:0] zr_ext, zi_ext;
  logic signed [PW-1:0] sq_r, sq_i, xprod;
  logic signed [PW-1:0] diff, twox;
  logic [PW-1:0]        mag;
  logic                 escape;
  logic                 at_limit;
  logic [DEPTH_WIDTH-1:0] lim_in;
  logic signed [WORD_LENGTH-1:0] zr_next, zi_next;

  // Datapath: full-width signed products of the registered z.
  always_comb begin
    zr_ext  = {{WORD_LENGTH{zr_q[WORD_LENGTH-1]}}, zr_q};
    zi_ext  = {{WORD_LENGTH{zi_q[WORD_LENGTH-1]}}, zi_q};
    sq_r    = zr_ext * zr_ext;
    sq_i    = zi_ext * zi_ext;
    xprod   = zr_ext * zi_ext;
    mag     = sq_r + sq_i;
    escape  = mag > EscThresh;
    diff    = sq_r - sq_i;
    twox    = xprod <<< 1;
    // Truncation to the word wraps on overflow; no saturation by design.
    zr_next = WORD_LENGTH'(diff >>> FRAC) + cre_q;
    zi_next = WORD_LENGTH'(twox >>> FRAC) + cim_q;
  end

  always_comb begin
    if (max_iter > 32'(IterCap)) begin
      lim_in = IterCap;
    end else begin
      lim_in = max_iter[DEPTH_WIDTH-1:0];
    end
  end

  assign at_limit  = iter_q >= lim_q;
  assign in_ready  = (state_q == StIdle) && init_q;
  assign out_valid = (state_q == StDone);
  assign depth     = depth_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;

  always_comb begin
    state_d = state_q;
    cre_d   = cre_q;
    cim_d   = cim_q;
    zr_d    = zr_q;
    zi_d    = zi_q;
    tag_x_d = tag_x_q;
    tag_y_d = tag_y_q;
    lim_d   = lim_q;
    iter_d  = iter_q;
    depth_d = depth_q;
    out_x_d = out_x_q;
    out_y_d = out_y_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          cre_d   = c_re;
          cim_d   = c_im;
          tag_x_d = in_x;
          tag_y_d = in_y;
          lim_d   = lim_in;
          zr_d    = '0;
          zi_d    = '0;
          iter_d  = '0;
          state_d = StIter;
        end
      end
      StIter: begin
        if (escape || at_limit) begin
          depth_d = iter_q;
          out_x_d = tag_x_q;
          out_y_d = tag_y_q;
          state_d = StDone;
        end else begin
          zr_d   = zr_next;
          zi_d   = zi_next;
          iter_d = iter_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // init_q holds in_ready low until the first edge after reset is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      init_q  <= 1'b0;
      cre_q   <= '0;
      cim_q   <= '0;
      zr_q    <= '0;
      zi_q    <= '0;
      tag_x_q <= '0;
      tag_y_q <= '0;
      lim_q   <= '0;
      iter_q  <= '0;
      depth_q <= '0;
      out_x_q <= '0;
      out_y_q <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
      cre_q   <= cre_d;
      cim_q   <= cim_d;
      zr_q    <= zr_d;
      zi_q    <= zi_d;
      tag_x_q <= tag_x_d;
      tag_y_q <= tag_y_d;
      lim_q   <= lim_d;
      iter_q  <= iter_d;
      depth_q <= depth_d;
      out_x_q <= out_x_d;
      out_y_q <= out_y_d;
    end
  end

endmodule

// File: tb/tb_mandelbrot_depth_unit.sv
// Directed bench for mandelbrot_depth_unit: hand-computed depths, latencies,
// backpressure hold and mid-iteration reset.
module tb_mandelbrot_depth_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] c_re, c_im;
  logic [10:0] in_x, in_y;
  logic [31:0] max_iter;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  depth;
  logic [10:0] out_x, out_y;
  logic        out_valid;
  logic        out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  mandelbrot_depth_unit dut (
    .clk       (clk),
    .reset     (reset),
    .c_re      (c_re),
    .c_im      (c_im),
    .in_x      (in_x),
    .in_y      (in_y),
    .max_iter  (max_iter),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .depth     (depth),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic send(input logic [31:0] cr, input logic [31:0] ci, input logic [10:0] x,
                      input logic [10:0] y, input logic [31:0] mi);
    int w = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_ready: in_ready=%b required 1", in_ready);
    end
    c_re = cr; c_im = ci; in_x = x; in_y = y; max_iter = mi; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Returns the number of edges after the accept edge until out_valid is seen.
  task automatic wait_result(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (out_valid !== 1'b1 && n < 3000);
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    c_re = '0; c_im = '0; in_x = '0; in_y = '0; max_iter = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_flags: in_ready,out_valid=%b required 00", {in_ready, out_valid});
    end
    n_checks++;
    if ({depth, out_x, out_y} !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: depth=%0d x=%0d y=%0d required 0", depth, out_x, out_y);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_before_edge: in_ready=%b required 0", in_ready);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_edge: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_zero_point();
    int n;
    send(32'h0, 32'h0, 11'd5, 11'd7, 32'd512);
    n_checks++;
    if ({in_ready, out_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL busy_flags: in_ready,out_valid=%b required 00", {in_ready, out_valid});
    end
    wait_result(n);
    n_checks++;
    if (n !== 513) begin
      n_fail++;
      $display("FAIL zero_latency: got %0d required 513", n);
    end
    n_checks++;
    if ({depth, out_x, out_y} !== {10'd512, 11'd5, 11'd7}) begin
      n_fail++;
      $display("FAIL zero_result: depth=%0d x=%0d y=%0d required 512 5 7", depth, out_x, out_y);
    end
    release_result();
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL zero_release: in_ready,out_valid=%b required 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_escape_one();
    int n;
    send(32'h1000_0000, 32'h0, 11'd100, 11'd200, 32'd512);
    wait_result(n);
    n_checks++;
    if (n !== 4) begin
      n_fail++;
      $display("FAIL one_latency: got %0d required 4", n);
    end
    n_checks++;
    if ({depth, out_x, out_y} !== {10'd3, 11'd100, 11'd200}) begin
      n_fail++;
      $display("FAIL one_result: depth=%0d x=%0d y=%0d required 3 100 200", depth, out_x, out_y);
    end
    release_result();
  endtask

  task automatic test_minus_two();
    int n;
    send(32'hE000_0000, 32'h0, 11'd1, 11'd2, 32'd100);
    wait_result(n);
    n_checks++;
    if (n !== 101) begin
      n_fail++;
      $display("FAIL m2_latency: got %0d required 101", n);
    end
    n_checks++;
    if (depth !== 10'd100) begin
      n_fail++;
      $display("FAIL m2_depth: got %0d required 100", depth);
    end
    release_result();
  endtask

  task automatic test_limits();
    int n;
    send(32'hE000_0000, 32'h0, 11'd3, 11'd4, 32'd0);
    wait_result(n);
    n_checks++;
    if (n !== 1 || depth !== 10'd0) begin
      n_fail++;
      $display("FAIL lim0: latency=%0d depth=%0d required 1 0", n, depth);
    end
    release_result();
    send(32'h0, 32'h0, 11'd2047, 11'd1024, 32'd2000);
    wait_result(n);
    n_checks++;
    if (n !== 1024) begin
      n_fail++;
      $display("FAIL clamp_latency: got %0d required 1024", n);
    end
    n_checks++;
    if ({depth, out_x, out_y} !== {10'd1023, 11'd2047, 11'd1024}) begin
      n_fail++;
      $display("FAIL clamp_result: depth=%0d x=%0d y=%0d required 1023 2047 1024",
               depth, out_x, out_y);
    end
    release_result();
  endtask

  task automatic test_backpressure();
    int n;
    send(32'h1000_0000, 32'h0, 11'd9, 11'd3, 32'd512);
    wait_result(n);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      c_re = 32'h0; max_iter = 32'd7; in_x = 11'(i); in_y = 11'(i + 50); in_valid = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if ({out_valid, in_ready, depth, out_x, out_y} !== {2'b10, 10'd3, 11'd9, 11'd3}) begin
        n_fail++;
        $display("FAIL hold_%0d: valid=%b ready=%b depth=%0d x=%0d y=%0d required 1 0 3 9 3",
                 i, out_valid, in_ready, depth, out_x, out_y);
      end
    end
    in_valid = 1'b0;
    release_result();
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_release: in_ready,out_valid=%b required 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_reset_mid_iter();
    int n;
    send(32'h0, 32'h0, 11'd11, 11'd12, 32'd512);
    repeat (50) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, in_ready, depth, out_x, out_y} !== 34'd0) begin
      n_fail++;
      $display("FAIL mid_reset: valid=%b ready=%b depth=%0d x=%0d y=%0d required all 0",
               out_valid, in_ready, depth, out_x, out_y);
    end
    @(negedge clk);
    reset = 1'b0;
    send(32'h1000_0000, 32'h0, 11'd2, 11'd4, 32'd512);
    wait_result(n);
    n_checks++;
    if (n !== 4 || {depth, out_x, out_y} !== {10'd3, 11'd2, 11'd4}) begin
      n_fail++;
      $display("FAIL after_reset: latency=%0d depth=%0d x=%0d y=%0d required 4 3 2 4",
               n, depth, out_x, out_y);
    end
    release_result();
  endtask

  initial begin
    test_reset();
    test_zero_point();
    test_escape_one();
    test_minus_two();
    test_limits();
    test_backpressure();
    test_reset_mid_iter();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mandelbrot_depth_unit.md
Name: mandelbrot_depth_unit

Overview:
- Single iterative Mandelbrot escape-time core.
- Accepts one complex point c (signed fixed point, FRAC fractional bits) plus its pixel coordinates, iterates z = z^2 + c from z = 0, and returns the escape depth with the coordinates.
- It is the compute stage directly upstream of the pixel generator's colour mapping. The engine wrapper fans several instances out and collects their depths.
- Output depth is 10 bits, matching the depth consumed by the colour map.

Parameters:
WORD_LENGTH, 32, width of c and z words (signed two's complement)
FRAC, 28, fractional bits of c and z
DEPTH_WIDTH, 10, width of depth output and iteration counter
COORD_WIDTH, 11, width of pixel x/y tags

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-high reset
c_re  in  WORD_LENGTH  real part of c, signed QFRAC
c_im  in  WORD_LENGTH  imaginary part of c, signed QFRAC
in_x  in  COORD_WIDTH  pixel x tag, passed through
in_y  in  COORD_WIDTH  pixel y tag, passed through
max_iter  in  32  iteration limit, sampled at accept
in_valid  in  1  input point valid
in_ready  out  1  core can accept a point
depth  out  DEPTH_WIDTH  escape iteration count
out_x  out  COORD_WIDTH  tag of the point producing depth
out_y  out  COORD_WIDTH  tag of the point producing depth
out_valid  out  1  depth/out_x/out_y valid
out_ready  in  1  consumer accepts result

Behaviour:
- Reset: one clock with an asynchronous, active-high reset.
  - While reset is high: state=IDLE, in_ready=0, out_valid=0, depth=0, out_x=0, out_y=0, zr=zi=0, iter=0.
  - in_ready goes to 1 at the first clock edge after reset deasserts.
  - Reset during ITER or DONE discards the point; no output is produced.
- States: IDLE, ITER, DONE.
- in_ready = (state==IDLE). out_valid = (state==DONE).
- IDLE:
  - On in_valid & in_ready: latch c_re, c_im, in_x, in_y; zr=zi=0; iter=0.
  - lim = min(max_iter, 2^DEPTH_WIDTH-1), i.e. 1023 by default. max_iter is ignored after accept.
  - Go to ITER.
- ITER, one iteration per cycle, on registered zr, zi:
  - sq_r = zr*zr, sq_i = zi*zi, x = zr*zi, all full 2*WORD_LENGTH signed products.
  - mag = sq_r + sq_i, as a 2*WORD_LENGTH unsigned value (no overflow for the Q4.28 range).
  - Escape when mag > (4 << 2*FRAC), strict. A magnitude of exactly 4.0 does not escape.
  - If escape or iter >= lim: depth <= iter, out_x/out_y <= latched tags, go to DONE.
  - Else:
    - zr <= ((sq_r - sq_i) >>> FRAC) + c_re
    - zi <= ((x <<< 1) >>> FRAC) + c_im
    - Both truncated to WORD_LENGTH, arithmetic-shift floor, wrap on overflow, no saturation.
    - iter <= iter + 1.
- Latency: accept edge t0, then out_valid is high from edge t0+depth+1 (depth+1 ITER cycles). lim=0 gives depth=0 and out_valid after 1 edge.
- DONE:
  - depth, out_x, out_y are held stable while out_valid=1 & !out_ready.
  - On out_ready, go to IDLE. in_ready is low in DONE; there is no same-cycle re-accept.
  - Throughput is one point per depth+3 cycles.
- in_valid while busy is ignored; the upstream holds the point until in_ready.
- Non-escaping points report depth = lim. The colour map treats depth >= MAX_ITER as inside.

Test Plan:
- Reset then c=(0,0), max_iter=512, in_x=5, in_y=7 -> out_valid 513 clocks after accept, depth=512, out_x=5, out_y=7.
- c=(0x10000000,0) (1.0), max_iter=512 -> z sequence 0,1,2,5; depth=3, out_valid 4 clocks after accept.
- c=(0xE0000000,0) (-2.0), max_iter=100 -> |z|^2 stays exactly 4.0 (strict compare, no escape); depth=100.
- max_iter=0 -> depth=0, out_valid 1 clock after accept. Then max_iter=2000, c=0 -> depth clamps to 1023.
- Backpressure: hold out_ready=0 for 20 cycles with result valid -> depth/out_x/out_y stable, in_ready=0, new in_valid ignored. Release -> IDLE next edge, in_ready=1.
- Assert reset for 1 cycle mid-ITER (c=0, max_iter=512, 50 clocks in) -> out_valid=0, depth=0, in_ready=0 during reset. Next point c=1.0 returns depth=3 correctly.
